icache_direct: RTL and testbench

Direct-mapped, one-word-block instruction cache sitting between the datapath's instruction-fetch port (imemREN/imemaddr -> ihit/imemload) and the memory controller's instruction port (iREN/iaddr <- iwait/iload). Hits return the instruction combinationally in the same cycle. Misses stall the datapath (ihit low) while a single-word fill is fetched from memory. The cache is read-only; the datapath never writes instructions through it.

---
 rtl/icache_direct.sv | 96 +++++++++
 tb/tb_icache_direct.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-block instruction cache.
// Hits are combinational; a miss fetches a single word from memory.
module icache_direct #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - 2;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t state, state_n;

  logic [SETS-1:0]   valid;
  logic [TW-1:0]     tags [SETS];
  logic [WORD_W-1:0] data [SETS];
  logic [31:0]       fill_addr;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] fidx;
  logic [TW-1:0] ftag;
  logic          hit;
  logic          latch;
  logic          write;

  assign idx  = imemaddr[IW+1:2];
  assign tag  = imemaddr[31:IW+2];
  assign fidx = fill_addr[IW+1:2];
  assign ftag = fill_addr[31:IW+2];

  always_comb begin
    state_n  = state;
    hit      = 1'b0;
    ihit     = 1'b0;
    iREN     = 1'b0;
    latch    = 1'b0;
    write    = 1'b0;
    iaddr    = fill_addr;
    imemload = data[idx];
    unique case (state)
      IDLE: begin
        hit  = imemREN & valid[idx] & (tags[idx] == tag);
        ihit = hit;
        if (imemREN && !hit) begin
          latch   = 1'b1;
          state_n = FETCH;
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          write   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      fill_addr <= '0;
    end else begin
      state <= state_n;
      if (latch) fill_addr <= {imemaddr[31:2], 2'b00};
      if (write) valid[fidx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; only the valid bits do.
  always_ff @(posedge CLK) begin
    if (!RST && write) begin
      tags[fidx] <= ftag;
      data[fidx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios then random traffic,
// checked against a frame-level model of the cache.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int n_cmp = 0;
  int n_bad = 0;

  icache_direct dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  // Model: each frame remembers the full word address it holds.
  bit          m_val [16];
  logic [31:0] m_wa  [16];
  logic [31:0] m_dat [16];
  bit          m_busy;
  logic [31:0] m_pend;

  task automatic chk(string t, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic step();
    int          i;
    logic [31:0] wa;
    bit          eh;
    #1;
    wa = imemaddr & 32'hFFFF_FFFC;
    i  = int'((imemaddr >> 2) % 16);
    eh = !m_busy && imemREN && m_val[i] && (m_wa[i] == wa);
    chk("ihit", {31'd0, ihit}, {31'd0, eh});
    chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
    chk("iaddr", iaddr, m_pend);
    if (m_val[i]) chk("imemload", imemload, m_dat[i]);
    @(posedge CLK);
    if (RST) begin
      m_busy = 0;
      m_pend = 0;
      foreach (m_val[k]) m_val[k] = 0;
    end else if (m_busy) begin
      if (!iwait) begin
        i = int'((m_pend >> 2) % 16);
        m_val[i] = 1;
        m_wa[i]  = m_pend;
        m_dat[i] = iload;
        m_busy   = 0;
      end
    end else if (imemREN && !eh) begin
      m_pend = wa;
      m_busy = 1;
    end
    #1;
  endtask

  task automatic req(logic [31:0] a, bit w);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = w;
  endtask

  initial begin
    m_busy = 0;
    m_pend = 0;
    foreach (m_val[k]) m_val[k] = 0;
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0;
    iwait = 1'b1; iload = '0;
    @(posedge CLK); #1;
    step();
    RST = 1'b0;

    // Basic miss then hit.
    req(32'h40, 1'b0); iload = 32'hDEAD_BEEF;
    step();
    #1 chk("fetch_iaddr", iaddr, 32'h40);
    step();
    #1 chk("fill_hit", {31'd0, ihit}, 32'd1);
    chk("fill_data", imemload, 32'hDEAD_BEEF);
    step();
    req(32'h43, 1'b0);
    #1 chk("alias_hit", {31'd0, ihit}, 32'd1);
    step();

    // Conflict on index 1.
    req(32'h04, 1'b0); iload = 32'h1111_0004;
    repeat (3) step();
    req(32'h44, 1'b0); iload = 32'h2222_0044;
    step();
    #1 chk("conflict_iaddr", iaddr, 32'h44);
    repeat (2) step();
    req(32'h04, 1'b1);
    #1 chk("evicted", {31'd0, ihit}, 32'd0);
    step();

    // Long iwait.
    iwait = 1'b0; iload = 32'h1111_0004;
    step();
    req(32'h80, 1'b1); iload = 32'hCAFE_0080;
    repeat (6) step();
    iwait = 1'b0;
    repeat (2) step();

    // Address change mid-fetch does not abort.
    req(32'hC0, 1'b1); iload = 32'hABCD_00C0;
    step();
    imemREN = 1'b0; imemaddr = 32'h100;
    repeat (2) step();
    iwait = 1'b0;
    step();
    req(32'hC0, 1'b0);
    #1 chk("orig_hit", {31'd0, ihit}, 32'd1);
    chk("orig_data", imemload, 32'hABCD_00C0);
    step();

    // Reset during fetch.
    req(32'h200, 1'b1);
    repeat (2) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1 chk("rst_iren", {31'd0, iREN}, 32'd0);
    step();
    iwait = 1'b0;
    repeat (3) step();

    // Random traffic over a small address pool.
    for (int n = 0; n < 400; n++) begin
      imemREN  = ($urandom % 4) != 0;
      imemaddr = ($urandom_range(0, 2) << 6) | ($urandom % 64);
      if ($urandom % 8 == 0) imemaddr = imemaddr | 32'h8000_0000;
      iwait    = ($urandom % 3) == 0;
      iload    = $urandom;
      RST      = ($urandom % 60) == 0;
      step();
    end
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
